// File: rtl/core_ctrl_issue_q_pkg.sv
// Shared types for the IDU->EXU issue queue.
// Contents: GPR index width, operand descriptor structs, and the x0 sanitise helper.
// The stored entry layout is {rd, rs2, rs1, payload}, with each operand packed as {vld, idx}.
package core_ctrl_issue_q_pkg;

  localparam int unsigned GPR_IDX_W = 5;
  localparam int unsigned NUM_GPR   = 32;

  typedef logic [GPR_IDX_W-1:0] gpr_idx_t;

  // One register operand reference.
  typedef struct packed {
    logic     vld;
    gpr_idx_t idx;
  } gpr_ref_t;

  // Operand block stored above the payload in each queue entry.
  typedef struct packed {
    gpr_ref_t rd;
    gpr_ref_t rs2;
    gpr_ref_t rs1;
  } opnd_t;

  localparam int unsigned OPND_W = $bits(opnd_t);

  // x0 is hardwired zero, so the scoreboard must never mark it busy or wait on it.
  function automatic gpr_ref_t sanitise_ref(input logic vld, input gpr_idx_t idx);
    gpr_ref_t r;
    r.vld = vld & (idx != '0);
    r.idx = idx;
    return r;
  endfunction

endpackage

// File: rtl/core_ctrl_issue_q_if.sv
// Handshake bundle around the issue queue.
// It carries the IDU enqueue side, the scoreboard emit/ready pair, and the EXU dispatch side.
// Modports:
//   slave  - the issue queue itself.
//   master - the surrounding environment: IDU, scoreboard and EXU.
interface core_ctrl_issue_q_if
  import core_ctrl_issue_q_pkg::*;
#(
  parameter int unsigned PLD_W = 64
);

  // IDU -> queue
  logic             idu_vld;
  logic             idu_rdy;
  logic [PLD_W-1:0] idu_pld;
  logic             idu_rs1_vld;
  gpr_idx_t         idu_rs1_idx;
  logic             idu_rs2_vld;
  gpr_idx_t         idu_rs2_idx;
  logic             idu_rd_vld;
  gpr_idx_t         idu_rd_idx;

  // queue <-> scoreboard
  logic             scb_emit_idx_valid;
  logic             scb_emit_rs1_vld;
  gpr_idx_t         scb_emit_rs1_idx;
  logic             scb_emit_rs2_vld;
  gpr_idx_t         scb_emit_rs2_idx;
  logic             scb_emit_rd_vld;
  gpr_idx_t         scb_emit_rd_idx;
  logic             reg_rs_ready;

  // queue -> EXU
  logic             exu_vld;
  logic             exu_rdy;
  logic [PLD_W-1:0] exu_pld;
  logic             exu_rd_vld;
  gpr_idx_t         exu_rd_idx;

  modport slave (
    input  idu_vld, idu_pld, idu_rs1_vld, idu_rs1_idx, idu_rs2_vld, idu_rs2_idx,
           idu_rd_vld, idu_rd_idx, reg_rs_ready, exu_rdy,
    output idu_rdy, scb_emit_idx_valid, scb_emit_rs1_vld, scb_emit_rs1_idx,
           scb_emit_rs2_vld, scb_emit_rs2_idx, scb_emit_rd_vld, scb_emit_rd_idx,
           exu_vld, exu_pld, exu_rd_vld, exu_rd_idx
  );

  modport master (
    output idu_vld, idu_pld, idu_rs1_vld, idu_rs1_idx, idu_rs2_vld, idu_rs2_idx,
           idu_rd_vld, idu_rd_idx, reg_rs_ready, exu_rdy,
    input  idu_rdy, scb_emit_idx_valid, scb_emit_rs1_vld, scb_emit_rs1_idx,
           scb_emit_rs2_vld, scb_emit_rs2_idx, scb_emit_rd_vld, scb_emit_rd_idx,
           exu_vld, exu_pld, exu_rd_vld, exu_rd_idx
  );

endinterface

// File: rtl/core_ctrl_issue_q_fifo.sv
// Generic synchronous FIFO with a combinational head and a synchronous flush.
// Ports:
//   clk, rst                      clock and async active-high reset
//   push_i, pop_i, flush_i        controls; flush has priority over push and pop
//   din_i                         write data
//   dout_o                        head entry, valid whenever empty_o = 0
//   full_o, empty_o, count_o      status
// Pointers carry one extra wrap bit, so full and empty can be told apart without a counter.
module core_ctrl_issue_q_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Status derived from the pointers.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Guard against overflow and underflow even when the caller misbehaves.
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Next-state pointer logic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers already mark every slot as empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/core_ctrl_issue_q.sv
// In-order issue queue between IDU and EXU.
// It presents the head entry to the register scoreboard. It dispatches the head to EXU only when
// every used operand is ready and EXU accepts.
// Ports:
//   clk, rst      clock and async active-high reset
//   flush         redirect; empties the queue at the next edge and blocks push and fire now
//   bus (slave)   IDU enqueue, scoreboard emit/ready, and EXU dispatch handshakes
//   occupancy     number of entries held
//   stall_cnt     saturating count of cycles the head was blocked by the scoreboard
module core_ctrl_issue_q
  import core_ctrl_issue_q_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PLD_W = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  core_ctrl_issue_q_if.slave     bus,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int unsigned ENTRY_W = PLD_W + OPND_W;

  logic               full, empty, head_vld;
  logic               push, fire;
  opnd_t              wr_opnd, head_opnd;
  logic [ENTRY_W-1:0] wr_entry, head_entry;
  logic [PLD_W-1:0]   head_pld;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  // Enqueue side: x0 operands are stored as unused.
  always_comb begin
    wr_opnd     = '0;
    wr_opnd.rs1 = sanitise_ref(bus.idu_rs1_vld, bus.idu_rs1_idx);
    wr_opnd.rs2 = sanitise_ref(bus.idu_rs2_vld, bus.idu_rs2_idx);
    wr_opnd.rd  = sanitise_ref(bus.idu_rd_vld,  bus.idu_rd_idx);
  end

  assign wr_entry    = {wr_opnd, bus.idu_pld};
  assign bus.idu_rdy = ~full & ~rst;
  assign push        = bus.idu_vld & bus.idu_rdy & ~flush;

  core_ctrl_issue_q_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (fire),
    .flush_i (flush),
    .din_i   (wr_entry),
    .dout_o  (head_entry),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occupancy)
  );

  // Head decode.
  assign head_vld  = ~empty;
  assign head_opnd = head_entry[ENTRY_W-1:PLD_W];
  assign head_pld  = head_entry[PLD_W-1:0];

  // Scoreboard view of the head; valids are gated so an empty queue requests nothing.
  assign bus.scb_emit_rs1_vld = head_vld & head_opnd.rs1.vld;
  assign bus.scb_emit_rs1_idx = head_opnd.rs1.idx;
  assign bus.scb_emit_rs2_vld = head_vld & head_opnd.rs2.vld;
  assign bus.scb_emit_rs2_idx = head_opnd.rs2.idx;
  assign bus.scb_emit_rd_vld  = head_vld & head_opnd.rd.vld;
  assign bus.scb_emit_rd_idx  = head_opnd.rd.idx;

  // The emit strobe ignores reg_rs_ready on purpose. The scoreboard ANDs it in, so rd goes busy
  // exactly on fire without a combinational loop through the scoreboard.
  assign bus.scb_emit_idx_valid = head_vld & bus.exu_rdy & ~flush;

  // Dispatch.
  assign bus.exu_vld    = head_vld & bus.reg_rs_ready & ~flush;
  assign fire           = bus.exu_vld & bus.exu_rdy;
  assign bus.exu_pld    = head_pld;
  assign bus.exu_rd_vld = head_opnd.rd.vld;
  assign bus.exu_rd_idx = head_opnd.rd.idx;

  // Stall counter: counts scoreboard-blocked head cycles and saturates; only reset clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (head_vld && !bus.reg_rs_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_core_ctrl_issue_q.sv
// Directed, table-driven bench for core_ctrl_issue_q (DEPTH=2, PLD_W=64, CNT_W=4).
// Inputs are driven on the falling edge and outputs are sampled 1 ns later, before the next rising edge.
module tb_core_ctrl_issue_q;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] occupancy;
  logic [3:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  core_ctrl_issue_q_if #(.PLD_W(64)) bus ();

  core_ctrl_issue_q #(
    .DEPTH (2),
    .PLD_W (64),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [63:0] pld;
    logic        rs1v;
    logic [4:0]  rs1;
    logic        rdv;
    logic [4:0]  rd;
    logic        rr;
    logic        er;
    logic        fl;
    logic        x_rdy;
    logic        x_ev;
    logic        x_siv;
    logic        x_srdv;
    logic        x_sr1v;
    logic [1:0]  x_occ;
    logic [3:0]  x_scnt;
    logic [63:0] x_pld;
    logic [4:0]  x_rd;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  // rs2 mirrors rs1, so rs2 sanitising and forwarding are covered as well.
  task automatic drive(input logic iv, input logic [63:0] pld, input logic rs1v, input logic [4:0] rs1,
                       input logic rdv, input logic [4:0] rd, input logic rr, input logic er,
                       input logic fl);
    bus.idu_vld      = iv;
    bus.idu_pld      = pld;
    bus.idu_rs1_vld  = rs1v;
    bus.idu_rs1_idx  = rs1;
    bus.idu_rs2_vld  = rs1v;
    bus.idu_rs2_idx  = rs1;
    bus.idu_rd_vld   = rdv;
    bus.idu_rd_idx   = rd;
    bus.reg_rs_ready = rr;
    bus.exu_rdy      = er;
    flush            = fl;
  endtask

  initial begin
    // iv pld               rs1v rs1 rdv rd  rr er fl | rdy ev siv srdv sr1v occ scnt x_pld             x_rd
    vecs[0]  = '{1, 64'hA1, 0, 0, 1, 1,  1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 64'h0,  0};
    vecs[1]  = '{1, 64'hA2, 0, 0, 1, 2,  1, 1, 0,  1, 1, 1, 1, 0, 1, 0, 64'hA1, 1};
    vecs[2]  = '{1, 64'hA3, 1, 1, 1, 3,  1, 1, 0,  1, 1, 1, 1, 0, 1, 0, 64'hA2, 2};
    vecs[3]  = '{0, 64'h0,  0, 0, 0, 0,  1, 1, 0,  1, 1, 1, 1, 1, 1, 0, 64'hA3, 3};
    vecs[4]  = '{0, 64'h0,  0, 0, 0, 0,  1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 64'h0,  0};
    // RAW stall on x5
    vecs[5]  = '{1, 64'hB1, 1, 5, 1, 6,  0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 64'h0,  0};
    vecs[6]  = '{0, 64'h0,  0, 0, 0, 0,  0, 1, 0,  1, 0, 1, 1, 1, 1, 0, 64'h0,  6};
    vecs[7]  = '{0, 64'h0,  0, 0, 0, 0,  0, 1, 0,  1, 0, 1, 1, 1, 1, 1, 64'h0,  6};
    vecs[8]  = '{0, 64'h0,  0, 0, 0, 0,  0, 1, 0,  1, 0, 1, 1, 1, 1, 2, 64'h0,  6};
    vecs[9]  = '{0, 64'h0,  0, 0, 0, 0,  1, 1, 0,  1, 1, 1, 1, 1, 1, 3, 64'hB1, 6};
    vecs[10] = '{0, 64'h0,  0, 0, 0, 0,  1, 1, 0,  1, 0, 0, 0, 0, 0, 3, 64'h0,  0};
    // EXU backpressure, third op held
    vecs[11] = '{1, 64'hC1, 0, 0, 1, 7,  1, 0, 0,  1, 0, 0, 0, 0, 0, 3, 64'h0,  0};
    vecs[12] = '{1, 64'hC2, 0, 0, 1, 8,  1, 0, 0,  1, 1, 0, 1, 0, 1, 3, 64'hC1, 7};
    vecs[13] = '{1, 64'hC3, 0, 0, 1, 9,  1, 0, 0,  0, 1, 0, 1, 0, 2, 3, 64'hC1, 7};
    vecs[14] = '{1, 64'hC3, 0, 0, 1, 9,  1, 1, 0,  0, 1, 1, 1, 0, 2, 3, 64'hC1, 7};
    vecs[15] = '{1, 64'hC3, 0, 0, 1, 9,  1, 1, 0,  1, 1, 1, 1, 0, 1, 3, 64'hC2, 8};
    vecs[16] = '{0, 64'h0,  0, 0, 0, 0,  1, 1, 0,  1, 1, 1, 1, 0, 1, 3, 64'hC3, 9};
    vecs[17] = '{0, 64'h0,  0, 0, 0, 0,  1, 1, 0,  1, 0, 0, 0, 0, 0, 3, 64'h0,  0};
    // x0 sanitise on rd/rs1/rs2
    vecs[18] = '{1, 64'hD1, 1, 0, 1, 0,  1, 1, 0,  1, 0, 0, 0, 0, 0, 3, 64'h0,  0};
    vecs[19] = '{0, 64'h0,  0, 0, 0, 0,  1, 1, 0,  1, 1, 1, 0, 0, 1, 3, 64'hD1, 0};
    vecs[20] = '{0, 64'h0,  0, 0, 0, 0,  1, 1, 0,  1, 0, 0, 0, 0, 0, 3, 64'h0,  0};
    // flush while full, then flush blocking a push into an empty queue
    vecs[21] = '{1, 64'hE1, 0, 0, 1, 10, 1, 0, 0,  1, 0, 0, 0, 0, 0, 3, 64'h0,  0};
    vecs[22] = '{1, 64'hE2, 0, 0, 1, 11, 1, 0, 0,  1, 1, 0, 1, 0, 1, 3, 64'hE1, 10};
    vecs[23] = '{1, 64'hE3, 0, 0, 1, 12, 1, 1, 1,  0, 0, 0, 1, 0, 2, 3, 64'h0,  10};
    vecs[24] = '{0, 64'h0,  0, 0, 0, 0,  1, 1, 0,  1, 0, 0, 0, 0, 0, 3, 64'h0,  0};
    vecs[25] = '{1, 64'hF1, 0, 0, 1, 13, 1, 1, 1,  1, 0, 0, 0, 0, 0, 3, 64'h0,  0};
    vecs[26] = '{0, 64'h0,  0, 0, 0, 0,  1, 1, 0,  1, 0, 0, 0, 0, 0, 3, 64'h0,  0};
    // a blocked head under flush does not count as a stall
    vecs[27] = '{1, 64'hF2, 1, 5, 1, 14, 0, 1, 0,  1, 0, 0, 0, 0, 0, 3, 64'h0,  0};
    vecs[28] = '{0, 64'h0,  0, 0, 0, 0,  0, 1, 1,  1, 0, 0, 1, 1, 1, 3, 64'h0,  14};
    vecs[29] = '{0, 64'h0,  0, 0, 0, 0,  1, 1, 0,  1, 0, 0, 0, 0, 0, 3, 64'h0,  0};

    // reset state
    rst = 1'b1;
    drive(0, 64'h0, 0, 0, 0, 0, 1, 1, 0);
    #2;
    chk("rst_idu_rdy", -1, 64'(bus.idu_rdy), 64'd0);
    chk("rst_exu_vld", -1, 64'(bus.exu_vld), 64'd0);
    chk("rst_emit_vld", -1, 64'(bus.scb_emit_idx_valid), 64'd0);
    chk("rst_occ", -1, 64'(occupancy), 64'd0);
    chk("rst_scnt", -1, 64'(stall_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].pld, vecs[i].rs1v, vecs[i].rs1, vecs[i].rdv, vecs[i].rd,
            vecs[i].rr, vecs[i].er, vecs[i].fl);
      #1;
      chk("idu_rdy", i, 64'(bus.idu_rdy), 64'(vecs[i].x_rdy));
      chk("exu_vld", i, 64'(bus.exu_vld), 64'(vecs[i].x_ev));
      chk("emit_idx_valid", i, 64'(bus.scb_emit_idx_valid), 64'(vecs[i].x_siv));
      chk("emit_rd_vld", i, 64'(bus.scb_emit_rd_vld), 64'(vecs[i].x_srdv));
      chk("emit_rs1_vld", i, 64'(bus.scb_emit_rs1_vld), 64'(vecs[i].x_sr1v));
      chk("emit_rs2_vld", i, 64'(bus.scb_emit_rs2_vld), 64'(vecs[i].x_sr1v));
      chk("occupancy", i, 64'(occupancy), 64'(vecs[i].x_occ));
      chk("stall_cnt", i, 64'(stall_cnt), 64'(vecs[i].x_scnt));
      if (vecs[i].x_ev) begin
        chk("exu_pld", i, bus.exu_pld, vecs[i].x_pld);
      end
      if (vecs[i].x_srdv) begin
        chk("emit_rd_idx", i, 64'(bus.scb_emit_rd_idx), 64'(vecs[i].x_rd));
        chk("exu_rd_idx", i, 64'(bus.exu_rd_idx), 64'(vecs[i].x_rd));
      end
    end

    // Async reset between edges discards a full queue and clears stall_cnt.
    @(negedge clk);
    drive(1, 64'hAA1, 0, 0, 1, 15, 1, 0, 0);
    @(negedge clk);
    drive(1, 64'hAA2, 0, 0, 1, 16, 1, 0, 0);
    @(negedge clk);
    drive(0, 64'h0, 0, 0, 0, 0, 1, 1, 0);
    #1;
    chk("pre_rst_occ", 100, 64'(occupancy), 64'd2);
    chk("pre_rst_exu_vld", 100, 64'(bus.exu_vld), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_idu_rdy", 101, 64'(bus.idu_rdy), 64'd0);
    chk("arst_exu_vld", 101, 64'(bus.exu_vld), 64'd0);
    chk("arst_emit_vld", 101, 64'(bus.scb_emit_idx_valid), 64'd0);
    chk("arst_emit_rd_vld", 101, 64'(bus.scb_emit_rd_vld), 64'd0);
    chk("arst_occ", 101, 64'(occupancy), 64'd0);
    chk("arst_scnt", 101, 64'(stall_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_idu_rdy", 102, 64'(bus.idu_rdy), 64'd1);
    chk("post_rst_occ", 102, 64'(occupancy), 64'd0);
    chk("post_rst_exu_vld", 102, 64'(bus.exu_vld), 64'd0);

    // Stall counter saturation: 20 blocked cycles saturate a 4-bit counter at 15.
    @(negedge clk);
    drive(1, 64'hBB1, 1, 5, 1, 17, 0, 1, 0);
    @(negedge clk);
    drive(0, 64'h0, 0, 0, 0, 0, 0, 1, 0);
    repeat (14) @(negedge clk);
    #1;
    chk("sat_scnt_14", 103, 64'(stall_cnt), 64'd14);
    repeat (6) @(negedge clk);
    #1;
    chk("sat_scnt_20", 104, 64'(stall_cnt), 64'd15);
    chk("sat_exu_vld", 104, 64'(bus.exu_vld), 64'd0);
    bus.reg_rs_ready = 1'b1;
    #1;
    chk("sat_release_exu_vld", 105, 64'(bus.exu_vld), 64'd1);
    chk("sat_release_pld", 105, bus.exu_pld, 64'hBB1);
    @(negedge clk);
    #1;
    chk("sat_after_fire_occ", 106, 64'(occupancy), 64'd0);
    chk("sat_after_fire_scnt", 106, 64'(stall_cnt), 64'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
